crosshair_move_ctrl: RTL and testbench
======================================

// Module: crosshair_move_ctrl
// PURPOSE
//   Control FSM directly upstream of the crosshair movement datapath. Synchronises the four
//   direction keys, generates a movement tick, and sequences the datapath's 4-bit control code
//   through erase -> step -> redraw, using the datapath's draw-done pulse to pace each
//   erase and redraw.
// PARAMETERS
//   TICK_DIV      833333  clk cycles per movement tick (50 MHz / 60 Hz); legal range >= 2
//   SYNC_STAGES   2       flip-flop stages in each key synchroniser; legal range >= 2
//   DRAW_TIMEOUT  15      max cycles spent waiting in CLEAR or DRAW before a forced advance
// PORTS
//   clk          in   1  system clock
//   reset_n      in   1  asynchronous, active-low reset
//   key_left     in   1  active-high, asynchronous to clk
//   key_right    in   1  active-high, asynchronous to clk
//   key_up       in   1  active-high, asynchronous to clk
//   key_down     in   1  active-high, asynchronous to clk
//   draw_done    in   1  datapath "4-pixel draw complete" flag; level, may stay high stale
//   control      out  4  datapath control code (see encodings)
//   busy         out  1  high whenever control != HOLD
//   err_timeout  out  1  sticky; set on any DRAW_TIMEOUT expiry, cleared only by reset
// BEHAVIOUR
//   Encodings (fixed): PREHOLD=0100 HOLD=0000 CLEAR=0001 LEFT=0011 RIGHT=0010
//     DOWN=0110 UP=0111 DRAW=0101. control is a registered state output.
//   Reset (async): control=PREHOLD, busy=1, err_timeout=0, tick counter=0,
//     synchronisers=0, latched keys=0, wait counter=0.
//   Tick: counter runs 0..TICK_DIV-1 and wraps; tick is a 1-cycle pulse on the wrap cycle.
//   Power-up sequence: PREHOLD (1 cycle) -> CLEAR (wait) -> DRAW (wait) -> HOLD.
//     This initial CLEAR makes the datapath load its home position (50,50).
//   HOLD: on tick, latch the synchronised keys into L,R,U,D.
//     If (L^R)|(U^D) -> CLEAR next cycle; otherwise stay in HOLD.
//     Opposing keys pressed together cancel on that axis.
//   Ticks arriving outside HOLD are dropped; they are never queued.
//   CLEAR/DRAW wait rule:
//     - draw_done is ignored in the first cycle of each CLEAR/DRAW visit (stale level).
//     - From cycle 2 on, draw_done=1 advances the FSM on the next edge.
//     - Wait counter resets on entry. If it reaches DRAW_TIMEOUT without an advance,
//       the FSM advances anyway and sets err_timeout.
//   Step phase after CLEAR: visit LEFT if L&~R, RIGHT if R&~L, DOWN if D&~U, UP if U&~D.
//     Each visited state lasts exactly 1 cycle, in that fixed order; non-qualifying
//     states are skipped. After the last step -> DRAW -> HOLD.
//   Latency: tick to CLEAR = 1 cycle.
//     Single-axis move: CLEAR(>=2) + 1 step + DRAW(>=2) cycles, then HOLD.
//   Key changes during a sequence have no effect until the next latch in HOLD.
//   Reset mid-sequence: immediate return to PREHOLD, then the full power-up sequence.
// TESTING (TICK_DIV=4, datapath model asserting draw_done in the 5th cycle of CLEAR/DRAW)
//   reset release, no keys -> PREHOLD,CLEAR x5,DRAW x5,HOLD.
//     Then HOLD is held indefinitely; busy=0 in HOLD.
//   key_right held, tick -> HOLD,CLEAR x5,RIGHT x1,DRAW x5,HOLD; repeats on every later tick.
//   key_left+key_up held -> CLEAR,LEFT,UP,DRAW in that order.
//     key_left+key_right held -> stays in HOLD on tick.
//   draw_done held high continuously -> each CLEAR/DRAW lasts exactly 2 cycles (first ignored).
//   draw_done stuck low -> CLEAR lasts 15 cycles, then a forced advance; err_timeout=1 and stays 1.
//   reset_n pulsed low during DRAW -> control=PREHOLD asynchronously; err_timeout cleared;
//     power-up sequence repeats.

Source files
------------

// File: rtl/crosshair_move_ctrl_if.sv
// Key/draw-done inputs and control-code outputs between the crosshair move controller
// and its surroundings (keys and the movement datapath).
interface crosshair_move_ctrl_if;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic       draw_done;
  logic [3:0] control;
  logic       busy;
  logic       err_timeout;

  modport master (
    input  key_left, key_right, key_up, key_down, draw_done,
    output control, busy, err_timeout
  );

  modport slave (
    output key_left, key_right, key_up, key_down, draw_done,
    input  control, busy, err_timeout
  );
endinterface

// File: rtl/crosshair_move_ctrl.sv
// Crosshair movement controller: key synchronisers, movement tick, and the
// erase -> step -> redraw control-code sequencer for the movement datapath.
module crosshair_key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else          sr <= {sr[STAGES-2:0], d};

  assign q = sr[STAGES-1];
endmodule

module crosshair_move_ctrl #(
  parameter int TICK_DIV     = 833333,
  parameter int SYNC_STAGES  = 2,
  parameter int DRAW_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  crosshair_move_ctrl_if.master bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(DRAW_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_PREHOLD = 4'b0100,
    S_HOLD    = 4'b0000,
    S_CLEAR   = 4'b0001,
    S_LEFT    = 4'b0011,
    S_RIGHT   = 4'b0010,
    S_DOWN    = 4'b0110,
    S_UP      = 4'b0111,
    S_DRAW    = 4'b0101
  } state_t;

  // key vector order: 0 left, 1 right, 2 up, 3 down
  logic [3:0] key_raw, key_s, key_q;
  assign key_raw = {bus.key_down, bus.key_up, bus.key_right, bus.key_left};

  for (genvar k = 0; k < 4; k++) begin : g_sync
    crosshair_key_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .reset_n(reset_n), .d(key_raw[k]), .q(key_s[k])
    );
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tick_cnt <= '0;
    else          tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

  state_t        state, nxt;
  logic [WW-1:0] wait_cnt;
  logic          busy_q, err_q;
  logic          go_h, go_v, waiting, dd_adv, to_adv;

  assign go_h    = key_q[0] ^ key_q[1];
  assign go_v    = key_q[2] ^ key_q[3];
  assign waiting = (state == S_CLEAR) || (state == S_DRAW);
  // First cycle of a visit ignores draw_done: it may still be high from the last draw.
  assign dd_adv  = (wait_cnt != '0) && bus.draw_done;
  assign to_adv  = (wait_cnt == WW'(DRAW_TIMEOUT - 1)) && !dd_adv;

  always_comb begin
    nxt = state;
    case (state)
      S_PREHOLD: nxt = S_CLEAR;
      S_HOLD:    if (tick && ((key_s[0] ^ key_s[1]) || (key_s[2] ^ key_s[3]))) nxt = S_CLEAR;
      S_CLEAR:   if (dd_adv || to_adv)
                   nxt = go_h ? (key_q[0] ? S_LEFT : S_RIGHT)
                       : go_v ? (key_q[3] ? S_DOWN : S_UP) : S_DRAW;
      S_LEFT,
      S_RIGHT:   nxt = go_v ? (key_q[3] ? S_DOWN : S_UP) : S_DRAW;
      S_DOWN,
      S_UP:      nxt = S_DRAW;
      S_DRAW:    if (dd_adv || to_adv) nxt = S_HOLD;
      default:   nxt = S_PREHOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= S_PREHOLD;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
      key_q    <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= nxt;
      busy_q   <= (nxt != S_HOLD);
      if (state == S_HOLD && tick) key_q <= key_s;
      wait_cnt <= (waiting && nxt == state) ? wait_cnt + WW'(1) : '0;
      if (waiting && to_adv) err_q <= 1'b1;
    end

  assign bus.control     = state;
  assign bus.busy        = busy_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_crosshair_move_ctrl.sv
// Directed bench for crosshair_move_ctrl with a small datapath model driving draw_done.
module tb_crosshair_move_ctrl;
  localparam logic [3:0] PREHOLD = 4'b0100, HOLD = 4'b0000, CLEAR = 4'b0001,
                         LEFT = 4'b0011, RIGHT = 4'b0010, DOWN = 4'b0110,
                         UP = 4'b0111, DRAW = 4'b0101;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   dd_mode = 1;  // 0 stuck low, 1 done in 5th cycle of a visit, 2 stuck high
  int   vcnt = 0;
  logic [3:0] prev_ctrl = 4'b0100;

  always #5 clk = ~clk;

  crosshair_move_ctrl_if bus();

  crosshair_move_ctrl #(.TICK_DIV(4), .SYNC_STAGES(2), .DRAW_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.control != prev_ctrl) vcnt = 1;
    else                          vcnt = vcnt + 1;
    prev_ctrl = bus.control;
    case (dd_mode)
      0:       bus.draw_done = 1'b0;
      2:       bus.draw_done = 1'b1;
      default: bus.draw_done = (vcnt == 5) && (bus.control == CLEAR || bus.control == DRAW);
    endcase
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Checks n cycles starting with the current one, ending on the next cycle's negedge.
  task automatic run(input string tag, input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].control", tag, i), bus.control, code);
      chk($sformatf("%s[%0d].busy", tag, i), {3'b0, bus.busy}, {3'b0, code != HOLD});
      @(negedge clk);
    end
  endtask

  task automatic leave(input string tag, input logic [3:0] code, input int budget);
    int n = 0;
    while (bus.control == code && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".left_state"}, {3'b0, bus.control != code}, 4'b0001);
  endtask

  task automatic set_keys(input logic l, input logic r, input logic u, input logic d);
    bus.key_left = l; bus.key_right = r; bus.key_up = u; bus.key_down = d;
  endtask

  initial begin
    set_keys(0, 0, 0, 0);
    bus.draw_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.control", bus.control, PREHOLD);
    chk("rst.busy", {3'b0, bus.busy}, 4'b0001);
    chk("rst.err", {3'b0, bus.err_timeout}, 4'b0000);
    reset_n = 1'b1;

    // power-up sequence, then idle HOLD
    run("pu.pre", PREHOLD, 1);
    run("pu.clr", CLEAR, 5);
    run("pu.drw", DRAW, 5);
    run("pu.hold", HOLD, 12);
    chk("pu.err", {3'b0, bus.err_timeout}, 4'b0000);

    // right held: two consecutive moves, released mid-redraw
    set_keys(0, 1, 0, 0);
    leave("r1", HOLD, 20);
    run("r1.clr", CLEAR, 5);
    run("r1.step", RIGHT, 1);
    run("r1.drw", DRAW, 5);
    run("r1.hold", HOLD, 1);
    leave("r2", HOLD, 20);
    run("r2.clr", CLEAR, 5);
    run("r2.step", RIGHT, 1);
    set_keys(0, 0, 0, 0);
    run("r2.drw", DRAW, 5);
    run("r2.hold", HOLD, 10);

    // left+up: both steps in fixed order
    set_keys(1, 0, 1, 0);
    leave("lu", HOLD, 20);
    run("lu.clr", CLEAR, 5);
    run("lu.left", LEFT, 1);
    run("lu.up", UP, 1);
    set_keys(0, 0, 0, 0);
    run("lu.drw", DRAW, 5);
    run("lu.hold", HOLD, 4);

    // left+right cancel: no movement across several ticks
    set_keys(1, 1, 0, 0);
    run("lr.hold", HOLD, 16);
    set_keys(0, 0, 0, 0);
    run("lr.drain", HOLD, 4);

    // draw_done stuck high: two-cycle waits
    dd_mode = 2;
    set_keys(0, 0, 0, 1);
    leave("dh", HOLD, 20);
    run("dh.clr", CLEAR, 2);
    run("dh.step", DOWN, 1);
    set_keys(0, 0, 0, 0);
    run("dh.drw", DRAW, 2);
    run("dh.hold", HOLD, 1);
    chk("dh.err", {3'b0, bus.err_timeout}, 4'b0000);

    // draw_done stuck low: forced advance after 15 cycles, sticky error
    dd_mode = 0;
    set_keys(0, 0, 1, 0);
    leave("dl", HOLD, 20);
    run("dl.clr", CLEAR, 15);
    chk("dl.err_set", {3'b0, bus.err_timeout}, 4'b0001);
    run("dl.step", UP, 1);
    set_keys(0, 0, 0, 0);
    run("dl.drw", DRAW, 15);
    run("dl.hold", HOLD, 8);
    chk("dl.err_sticky", {3'b0, bus.err_timeout}, 4'b0001);

    // reset mid-redraw
    dd_mode = 1;
    set_keys(0, 1, 0, 0);
    leave("rs", HOLD, 20);
    run("rs.clr", CLEAR, 5);
    run("rs.step", RIGHT, 1);
    run("rs.drw", DRAW, 1);
    set_keys(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rs.async_control", bus.control, PREHOLD);
    chk("rs.async_busy", {3'b0, bus.busy}, 4'b0001);
    chk("rs.async_err", {3'b0, bus.err_timeout}, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    run("rs.pre", PREHOLD, 1);
    run("rs.clr2", CLEAR, 5);
    run("rs.drw2", DRAW, 5);
    run("rs.hold", HOLD, 6);
    chk("rs.err_end", {3'b0, bus.err_timeout}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
